// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// iteration-counter sizing.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Counter must be able to hold WIDTH iterations.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/divider_sign_unit.sv
// Two-lane sign helper: absolute value / conditional negate per lane, sign
// extraction, and detection of the signed MIN / -1 overflow pair.
module divider_sign_unit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             signed_op,
  input  logic             neg_x,
  input  logic             neg_y,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic             x_sign,
  output logic             y_sign,
  output logic             min_neg1
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0][WIDTH-1:0] lane_in;
  logic [1:0][WIDTH-1:0] lane_out;
  logic [1:0]            lane_neg;
  logic [1:0]            lane_sign;

  assign lane_in  = {y, x};
  assign lane_neg = {neg_y, neg_x};

  // A negative operand is made positive; an explicit request negates unconditionally.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign lane_sign[gi] = signed_op & lane_in[gi][WIDTH-1];
    assign lane_out[gi]  = (lane_sign[gi] | lane_neg[gi]) ? (~lane_in[gi] + 1'b1)
                                                          : lane_in[gi];
  end

  assign x_out    = lane_out[0];
  assign y_out    = lane_out[1];
  assign x_sign   = lane_sign[0];
  assign y_sign   = lane_sign[1];
  assign min_neg1 = signed_op & (x == MIN_VAL) & (&y);

endmodule

// File: rtl/divider_seq_param.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per clock, with
// runtime signed/unsigned mode, remainder output and zero/overflow flags.
module divider_seq_param
  import divider_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] dvd_reg, dvd_next;
  logic [WIDTH-1:0] dvs_reg, dvs_next;
  logic             mode_reg, mode_next;
  logic [WIDTH-1:0] work_q_reg, work_q_next;
  logic [WIDTH:0]   prem_reg, prem_next;
  logic [WIDTH-1:0] dvs_abs_reg, dvs_abs_next;
  logic             q_neg_reg, q_neg_next;
  logic             r_neg_reg, r_neg_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             dbz_reg, dbz_next;
  logic             ovf_reg, ovf_next;
  logic             done_reg, done_next;

  logic [WIDTH+1:0] shifted;
  logic             ge;
  logic             in_fix;
  logic [WIDTH-1:0] su_x, su_y, su_x_out, su_y_out;
  logic             su_signed, su_neg_x, su_neg_y, su_x_sign, su_y_sign, su_min_neg1;

  // One sign unit serves both ends: operand conversion in PREP, result fix-up in FIX.
  assign in_fix    = (state_reg == FIX);
  assign su_x      = in_fix ? work_q_reg : dvd_reg;
  assign su_y      = in_fix ? prem_reg[WIDTH-1:0] : dvs_reg;
  assign su_signed = ~in_fix & mode_reg;
  assign su_neg_x  = in_fix & q_neg_reg;
  assign su_neg_y  = in_fix & r_neg_reg;

  divider_sign_unit #(.WIDTH(WIDTH)) u_sign (
    .x         (su_x),
    .y         (su_y),
    .signed_op (su_signed),
    .neg_x     (su_neg_x),
    .neg_y     (su_neg_y),
    .x_out     (su_x_out),
    .y_out     (su_y_out),
    .x_sign    (su_x_sign),
    .y_sign    (su_y_sign),
    .min_neg1  (su_min_neg1)
  );

  assign shifted = {prem_reg, work_q_reg[WIDTH-1]};
  assign ge      = (shifted >= {2'b00, dvs_abs_reg});

  always_comb begin
    state_next     = state_reg;
    dvd_next       = dvd_reg;
    dvs_next       = dvs_reg;
    mode_next      = mode_reg;
    work_q_next    = work_q_reg;
    prem_next      = prem_reg;
    dvs_abs_next   = dvs_abs_reg;
    q_neg_next     = q_neg_reg;
    r_neg_next     = r_neg_reg;
    cnt_next       = cnt_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;
    ovf_next       = ovf_reg;
    done_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          dvd_next   = dividend;
          dvs_next   = divisor;
          mode_next  = signed_mode & SIGNED_EN;
          state_next = PREP;
        end
      end
      PREP: begin
        if (dvs_reg == '0) begin
          quotient_next  = '1;
          remainder_next = dvd_reg;
          dbz_next       = 1'b1;
          ovf_next       = 1'b0;
          done_next      = 1'b1;
          state_next     = IDLE;
        end else if (su_min_neg1) begin
          quotient_next  = MIN_VAL;
          remainder_next = '0;
          dbz_next       = 1'b0;
          ovf_next       = 1'b1;
          done_next      = 1'b1;
          state_next     = IDLE;
        end else begin
          work_q_next  = su_x_out;
          dvs_abs_next = su_y_out;
          prem_next    = '0;
          q_neg_next   = su_x_sign ^ su_y_sign;
          r_neg_next   = su_x_sign;
          cnt_next     = '0;
          state_next   = CALC;
        end
      end
      CALC: begin
        // Quotient bits shift into the vacated LSBs of the dividend register.
        prem_next   = ge ? (shifted[WIDTH:0] - {1'b0, dvs_abs_reg}) : shifted[WIDTH:0];
        work_q_next = {work_q_reg[WIDTH-2:0], ge};
        cnt_next    = cnt_reg + 1'b1;
        if (cnt_reg == LAST_CNT) state_next = FIX;
      end
      FIX: begin
        quotient_next  = su_x_out;
        remainder_next = su_y_out;
        dbz_next       = 1'b0;
        ovf_next       = 1'b0;
        done_next      = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      mode_reg      <= 1'b0;
      work_q_reg    <= '0;
      prem_reg      <= '0;
      dvs_abs_reg   <= '0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dvd_reg       <= dvd_next;
      dvs_reg       <= dvs_next;
      mode_reg      <= mode_next;
      work_q_reg    <= work_q_next;
      prem_reg      <= prem_next;
      dvs_abs_reg   <= dvs_abs_next;
      q_neg_reg     <= q_neg_next;
      r_neg_reg     <= r_neg_next;
      cnt_reg       <= cnt_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
      ovf_reg       <= ovf_next;
      done_reg      <= done_next;
    end
  end

  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;
  assign overflow    = ovf_reg;

endmodule

// File: tb/tb_divider_seq_param.sv
// Directed bench for divider_seq_param: vector table at WIDTH=16 plus hand
// sequences for busy-start, mid-op reset and a WIDTH=8 unsigned-only build.
module tb_divider_seq_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, signed_mode;
  logic [15:0] dividend, divisor, quotient, remainder;
  logic        busy, done, div_by_zero, overflow;

  logic        start8, signed_mode8;
  logic [7:0]  dividend8, divisor8, quotient8, remainder8;
  logic        busy8, done8, div_by_zero8, overflow8;

  int n_cmp = 0;
  int n_bad = 0;

  divider_seq_param #(.WIDTH(16), .SIGNED_EN(1'b1)) dut16 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  divider_seq_param #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(signed_mode8),
    .dividend(dividend8), .divisor(divisor8), .busy(busy8), .done(done8),
    .quotient(quotient8), .remainder(remainder8),
    .div_by_zero(div_by_zero8), .overflow(overflow8)
  );

  typedef struct {
    logic        sm;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic launch(input logic sm, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    signed_mode = sm;
    dividend    = a;
    divisor     = b;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 60);
  endtask

  initial begin
    int lat;
    int done_cnt;

    vecs[0]  = '{1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 18};
    vecs[1]  = '{1'b1, 16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 18};
    vecs[2]  = '{1'b1, 16'd100,  16'hFFF9, 16'hFFF2, 16'd2,    1'b0, 1'b0, 18};
    vecs[3]  = '{1'b0, 16'd1234, 16'd0,    16'hFFFF, 16'd1234, 1'b1, 1'b0, 1};
    vecs[4]  = '{1'b0, 16'd50,   16'd5,    16'd10,   16'd0,    1'b0, 1'b0, 18};
    vecs[5]  = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'd0,    1'b0, 1'b1, 1};
    vecs[6]  = '{1'b0, 16'h8000, 16'hFFFF, 16'd0,    16'h8000, 1'b0, 1'b0, 18};
    vecs[7]  = '{1'b1, 16'h8000, 16'd0,    16'hFFFF, 16'h8000, 1'b1, 1'b0, 1};
    vecs[8]  = '{1'b1, 16'hFF9C, 16'hFFF9, 16'd14,   16'hFFFE, 1'b0, 1'b0, 18};
    vecs[9]  = '{1'b0, 16'hFFFF, 16'd1,    16'hFFFF, 16'd0,    1'b0, 1'b0, 18};
    vecs[10] = '{1'b0, 16'd7,    16'd100,  16'd0,    16'd7,    1'b0, 1'b0, 18};
    vecs[11] = '{1'b1, 16'h8000, 16'd2,    16'hC000, 16'd0,    1'b0, 1'b0, 18};
    vecs[12] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'd1,    16'd0,    1'b0, 1'b0, 18};

    rst = 1'b0; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
    start8 = 1'b0; signed_mode8 = 1'b0; dividend8 = '0; divisor8 = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_q", quotient, 16'd0);
    chk("rst_r", remainder, 16'd0);
    chk("rst_flags", {div_by_zero, overflow}, 2'b00);
    chk("rst_busy8", busy8, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      launch(vecs[i].sm, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_busy_start", i), busy, 1'b1);
      wait_done(0, lat);
      chk($sformatf("v%0d_q", i), quotient, vecs[i].q);
      chk($sformatf("v%0d_r", i), remainder, vecs[i].r);
      chk($sformatf("v%0d_dbz", i), div_by_zero, vecs[i].dbz);
      chk($sformatf("v%0d_ovf", i), overflow, vecs[i].ovf);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy_done", i), busy, 1'b0);
      $display("vec %0d: sm=%0d %h / %h -> q=%h r=%h dbz=%0d ovf=%0d lat=%0d",
               i, vecs[i].sm, vecs[i].a, vecs[i].b, quotient, remainder,
               div_by_zero, overflow, lat);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), done, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("hold_q", quotient, 16'd1);

    // Second start while busy must be ignored.
    launch(1'b0, 16'hFFFF, 16'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    dividend = 16'd9; divisor = 16'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(5, lat);
    chk("busy_start_q", quotient, 16'hFFFF);
    chk("busy_start_r", remainder, 16'd0);
    chk("busy_start_lat", lat, 18);
    $display("busy-start: 65535/1 with 9/3 at edge 5 -> q=%h r=%h lat=%0d", quotient, remainder, lat);
    @(posedge clk);
    #1;
    chk("busy_start_no_requeue", busy, 1'b0);

    // Reset in the middle of an operation: no done, everything cleared.
    launch(1'b0, 16'hFFFF, 16'd1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_q", quotient, 16'd0);
    chk("midrst_r", remainder, 16'd0);
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    chk("midrst_no_done", done_cnt, 0);
    launch(1'b0, 16'd100, 16'd7);
    wait_done(0, lat);
    chk("after_rst_q", quotient, 16'd14);
    chk("after_rst_r", remainder, 16'd2);
    chk("after_rst_lat", lat, 18);
    $display("mid-op reset then 100/7 -> q=%h r=%h lat=%0d", quotient, remainder, lat);

    // WIDTH=8, signed mode forced off: signed_mode=1 must not change the result.
    @(negedge clk);
    signed_mode8 = 1'b1; dividend8 = 8'd255; divisor8 = 8'd16; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done8 && lat < 40);
    chk("w8_q", quotient8, 8'd15);
    chk("w8_r", remainder8, 8'd15);
    chk("w8_lat", lat, 10);
    chk("w8_flags", {div_by_zero8, overflow8}, 2'b00);
    $display("w8: 255/16 -> q=%h r=%h lat=%0d", quotient8, remainder8, lat);

    // Back-to-back: start raised during the done cycle is accepted at the next edge.
    dividend8 = 8'd200; divisor8 = 8'd3; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    chk("w8_b2b_busy", busy8, 1'b1);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done8 && lat < 40);
    chk("w8_b2b_q", quotient8, 8'd66);
    chk("w8_b2b_r", remainder8, 8'd2);
    chk("w8_b2b_lat", lat, 10);
    $display("w8 back-to-back: 200/3 -> q=%h r=%h lat=%0d", quotient8, remainder8, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
